// File: rtl/ddram_gs_bridge.sv
`timescale 1ns/1ps
// ddram_gs_bridge
//
// Byte-wide General Sound memory port onto the 64-bit DDR3 (Avalon-MM style)
// interface. 8-bit reads and writes on a 21-bit byte address become
// single-beat 64-bit DDR transactions. A one-line (8-byte) read cache lets
// sequential GS fetches within a line complete without touching DDR.
//
// Ports
//   DDRAM_CLK         sole clock
//   RESET_N           asynchronous active-low reset
//   DDRAM_BUSY        controller stall; a command is taken on a clock with BUSY=0
//   DDRAM_BURSTCNT    constant 1 (single-beat transfers)
//   DDRAM_ADDR        64-bit word address {4'b0011, 7'b0, addr[20:3]}
//   DDRAM_DOUT        read data from DDR
//   DDRAM_DOUT_READY  read data valid strobe
//   DDRAM_RD          read command
//   DDRAM_DIN         write data, the GS byte replicated to all lanes
//   DDRAM_BE          one-hot byte enable, lane addr[2:0]
//   DDRAM_WE          write command
//   addr, din         GS byte address and write data
//   dout              GS read data (registered)
//   we, rd            GS write/read requests, acted on at their rising edge
//   ready             1 = idle or complete, 0 = transaction in progress
//   state_dbg         current FSM state (IDLE=0, RD_REQ=1, RD_WAIT=2, WR_REQ=3)
//
// Handshakes: on the GS side a request is a 0->1 edge of rd or we sampled
// while ready=1; ready falls the next clock for any DDR access and returns
// to 1 together with the result, edges seen while ready=0 are discarded.
// On the DDR side DDRAM_RD/DDRAM_WE act as valid and ~DDRAM_BUSY as ready:
// the command, with ADDR/DIN/BE held stable, is transferred on the first
// clock where it is asserted and DDRAM_BUSY=0.

module ddram_gs_bridge (
    input  logic        DDRAM_CLK,
    input  logic        RESET_N,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    input  logic [20:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        we,
    input  logic        rd,
    output logic        ready,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Edge-history registers for request detection.
    logic rd_q;
    logic we_q;

    // Single cache line.
    logic [63:0] line;
    logic [17:0] tag;
    logic        valid;

    // Address of the access in flight; selects the returned byte and the tag.
    logic [20:0] req_addr;

    logic rd_edge;
    logic we_edge;
    logic tag_hit;
    logic rd_hit;

    assign rd_edge = rd & ~rd_q;
    assign we_edge = we & ~we_q;
    // Write-through keys on the tag alone; updating a line that is not yet
    // valid is harmless because the next fill overwrites it.
    assign tag_hit = (tag == addr[20:3]);
    assign rd_hit  = valid && tag_hit;

    assign DDRAM_BURSTCNT = 8'd1;
    assign state_dbg      = state;

    // State register.
    always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. A write edge wins over a simultaneous read edge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (we_edge) begin
                    state_nx = WR_REQ;
                end else if (rd_edge && !rd_hit) begin
                    state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!DDRAM_BUSY) begin
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    state_nx = IDLE;
                end
            end
            WR_REQ: begin
                if (!DDRAM_BUSY) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs, cache and request capture.
    always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_q       <= 1'b0;
            we_q       <= 1'b0;
            ready      <= 1'b1;
            DDRAM_RD   <= 1'b0;
            DDRAM_WE   <= 1'b0;
            DDRAM_ADDR <= '0;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
            dout       <= '0;
            valid      <= 1'b0;
            tag        <= '0;
            line       <= '0;
            req_addr   <= '0;
        end else begin
            // History updates in every state, so edges arriving while
            // busy are consumed and lost rather than queued.
            rd_q <= rd;
            we_q <= we;
            case (state)
                IDLE: begin
                    if (we_edge) begin
                        req_addr   <= addr;
                        DDRAM_ADDR <= {4'b0011, 7'b0, addr[20:3]};
                        DDRAM_DIN  <= {8{din}};
                        DDRAM_BE   <= 8'b1 << addr[2:0];
                        DDRAM_WE   <= 1'b1;
                        ready      <= 1'b0;
                        if (tag_hit) begin
                            line[{addr[2:0], 3'b000} +: 8] <= din;
                        end
                    end else if (rd_edge) begin
                        if (rd_hit) begin
                            dout <= line[{addr[2:0], 3'b000} +: 8];
                        end else begin
                            req_addr   <= addr;
                            DDRAM_ADDR <= {4'b0011, 7'b0, addr[20:3]};
                            DDRAM_RD   <= 1'b1;
                            ready      <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        line  <= DDRAM_DOUT;
                        tag   <= req_addr[20:3];
                        valid <= 1'b1;
                        dout  <= DDRAM_DOUT[{req_addr[2:0], 3'b000} +: 8];
                        ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE <= 1'b0;
                        ready    <= 1'b1;
                    end
                end
                default: begin
                    DDRAM_RD <= 1'b0;
                    DDRAM_WE <= 1'b0;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_gs_bridge.sv
`timescale 1ns/1ps
module tb_ddram_gs_bridge;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET_N;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic [20:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        we;
    logic        rd;
    logic        ready;
    logic [1:0]  state_dbg;

    ddram_gs_bridge dut (
        .DDRAM_CLK        (clk),
        .RESET_N          (RESET_N),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_WE         (DDRAM_WE),
        .addr             (addr),
        .din              (din),
        .dout             (dout),
        .we               (we),
        .rd               (rd),
        .ready            (ready),
        .state_dbg        (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0]   exp_q[$];   // expected GS read bytes, in order
    logic [101:0] cmd_q[$];   // {is_wr, addr29, din64, be8} expected DDR commands
    int n_chk  = 0;
    int n_fail = 0;
    int n_rd_cmds = 0;
    int n_wr_cmds = 0;
    logic [28:0] last_wr_addr;
    logic [63:0] last_wr_din;
    logic [7:0]  last_wr_be;
    logic [28:0] last_rd_addr;

    // Reference model: flat byte memory plus which line the bridge holds.
    logic [7:0]  img [int];
    logic        m_valid;
    logic [17:0] m_tag;

    // Environment knobs.
    int  busy_set  = 0;
    int  busy_tok  = 0;
    bit  rand_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] img_byte(input logic [20:0] a);
        if (img.exists(int'(a))) return img[int'(a)];
        return a[7:0] ^ {a[12:8], 3'b101} ^ a[20:13];
    endfunction

    function automatic logic [63:0] ddr_word(input logic [17:0] wa);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = img_byte({wa, 3'(i)});
        return w;
    endfunction

    function automatic logic [28:0] word_addr(input logic [20:0] a);
        return {4'b0011, 7'b0, a[20:3]};
    endfunction

    // ---------------- DDR side models ----------------
    // BUSY generator: forced stall runs requested by the driver, else random.
    initial begin
        int hold = 0;
        int tok_seen = 0;
        DDRAM_BUSY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_tok != tok_seen) begin
                tok_seen = busy_tok;
                hold = busy_set;
            end
            if (hold > 0) begin
                DDRAM_BUSY = 1'b1;
                hold--;
            end else begin
                DDRAM_BUSY = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    // Read responder: data strobe one clock after the accepting clock,
    // plus random extra latency in random mode.
    initial begin
        logic [17:0] wa;
        int extra;
        DDRAM_DOUT = '0;
        DDRAM_DOUT_READY = 1'b0;
        forever begin
            @(negedge clk);
            if (RESET_N && DDRAM_RD && !DDRAM_BUSY) begin
                wa = DDRAM_ADDR[17:0];
                extra = rand_mode ? $urandom_range(0, 3) : 0;
                @(posedge clk);
                repeat (1 + extra) @(posedge clk);
                #1;
                DDRAM_DOUT = ddr_word(wa);
                DDRAM_DOUT_READY = 1'b1;
                @(posedge clk);
                #1;
                DDRAM_DOUT_READY = 1'b0;
                DDRAM_DOUT = {$urandom, $urandom};
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic rd_p, we_p, rdc_p, wec_p, pend;
        logic [101:0] e;
        rd_p = 0; we_p = 0; rdc_p = 0; wec_p = 0; pend = 0;
        forever begin
            @(negedge clk);
            if (!RESET_N) begin
                rd_p = 0; we_p = 0; rdc_p = 0; wec_p = 0; pend = 0;
            end else begin
                // GS read results
                if (pend && ready) begin
                    pend = 0;
                    if (exp_q.size() == 0) check("rd_data_unexpected", 64'(dout), 64'hx);
                    else check("rd_data", 64'(dout), 64'(exp_q.pop_front()));
                end
                if (ready && rd && !rd_p && !(we && !we_p)) pend = 1;
                rd_p = rd;
                we_p = we;
                // DDR commands
                if (DDRAM_RD && !rdc_p) begin
                    n_rd_cmds++;
                    last_rd_addr = DDRAM_ADDR;
                    check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
                    if (cmd_q.size() == 0) check("rd_cmd_unexpected", 64'(DDRAM_ADDR), 64'hx);
                    else begin
                        e = cmd_q.pop_front();
                        check("rd_cmd_kind", 64'(1'b0), 64'(e[101]));
                        check("rd_cmd_addr", 64'(DDRAM_ADDR), 64'(e[100:72]));
                    end
                end else if (DDRAM_RD) begin
                    check("rd_addr_stable", 64'(DDRAM_ADDR), 64'(last_rd_addr));
                end
                if (DDRAM_WE && !wec_p) begin
                    n_wr_cmds++;
                    last_wr_addr = DDRAM_ADDR;
                    last_wr_din  = DDRAM_DIN;
                    last_wr_be   = DDRAM_BE;
                    if (cmd_q.size() == 0) check("wr_cmd_unexpected", 64'(DDRAM_ADDR), 64'hx);
                    else begin
                        e = cmd_q.pop_front();
                        check("wr_cmd_kind", 64'(1'b1), 64'(e[101]));
                        check("wr_cmd_addr", 64'(DDRAM_ADDR), 64'(e[100:72]));
                        check("wr_cmd_din", DDRAM_DIN, e[71:8]);
                        check("wr_cmd_be", 64'(DDRAM_BE), 64'(e[7:0]));
                    end
                end else if (DDRAM_WE) begin
                    check("wr_fields_stable", {DDRAM_ADDR, DDRAM_BE, DDRAM_DIN[26:0]},
                          {last_wr_addr, last_wr_be, last_wr_din[26:0]});
                end
                rdc_p = DDRAM_RD;
                wec_p = DDRAM_WE;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("wait_idle_timeout", 64'(ready), 64'd1);
    endtask

    // One-cycle request pulse; the model predicts commands and read data.
    task automatic issue(input bit do_rd, input bit do_wr, input logic [20:0] a,
                         input logic [7:0] d, input int bsy);
        @(posedge clk);
        #2;
        if (do_wr) begin
            cmd_q.push_back({1'b1, word_addr(a), {8{d}}, 8'b1 << a[2:0]});
            img[int'(a)] = d;
        end else if (do_rd) begin
            if (!(m_valid && m_tag == a[20:3])) begin
                cmd_q.push_back({1'b0, word_addr(a), 64'd0, 8'd0});
                m_valid = 1'b1;
                m_tag   = a[20:3];
            end
            exp_q.push_back(img_byte(a));
        end
        busy_set = bsy;
        busy_tok++;
        addr = a;
        din  = d;
        rd   = do_rd;
        we   = do_wr;
        @(negedge clk);
        @(posedge clk);
        #2;
        rd = 1'b0;
        we = 1'b0;
    endtask

    task automatic measure(output int low, output int we_hi);
        int n = 0;
        low = 0;
        we_hi = 0;
        @(negedge clk);
        while (!ready && n < 500) begin
            low++;
            if (DDRAM_WE) we_hi++;
            @(negedge clk);
            n++;
        end
        if (!ready) check("measure_timeout", 64'(ready), 64'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int low, wh, rc0, wc0, op;
        logic [20:0] a;
        logic [17:0] lines [6];
        lines = '{18'h0, 18'h1, 18'h2, 18'h3FFFF, 18'h1234, 18'h20};

        RESET_N = 1'b0;
        rd = 0; we = 0; addr = '0; din = '0;
        m_valid = 0; m_tag = '0;
        for (int i = 0; i < 8; i++) img[8 + i] = 8'h11 * 8'(i + 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_rd", 64'(DDRAM_RD), 64'd0);
        check("rst_we", 64'(DDRAM_WE), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_addr", 64'(DDRAM_ADDR), 64'd0);
        check("rst_burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        @(posedge clk);
        #2;
        RESET_N = 1'b1;

        // Read miss, minimum latency.
        issue(1, 0, 21'h00009, 8'h00, 0);
        measure(low, wh);
        check("miss_ready_low", 64'(low), 64'd3);
        check("miss_ddr_addr", 64'(last_rd_addr), 64'h06000001);
        check("miss_dout", 64'(dout), 64'h22);

        // Read hit in the same line.
        rc0 = n_rd_cmds;
        issue(1, 0, 21'h0000F, 8'h00, 0);
        measure(low, wh);
        check("hit_ready_low", 64'(low), 64'd0);
        @(negedge clk);
        check("hit_dout", 64'(dout), 64'h88);

        // Write-through then hit.
        issue(0, 1, 21'h0000A, 8'h5A, 0);
        measure(low, wh);
        check("wr_min_ready_low", 64'(low), 64'd1);
        issue(1, 0, 21'h0000A, 8'h00, 0);
        measure(low, wh);
        check("wt_hit_ready_low", 64'(low), 64'd0);
        @(negedge clk);
        check("wt_dout", 64'(dout), 64'h5A);
        check("hit_no_rd_cmd", 64'(n_rd_cmds), 64'(rc0));

        // Write with three stall clocks.
        issue(0, 1, 21'h1FFFFA, 8'hA5, 3);
        measure(low, wh);
        check("stall_we_cycles", 64'(wh), 64'd4);
        check("stall_ready_low", 64'(low), 64'd4);
        check("stall_addr", 64'(last_wr_addr), 64'h0603FFFF);
        check("stall_din", last_wr_din, 64'hA5A5A5A5A5A5A5A5);
        check("stall_be", 64'(last_wr_be), 64'h04);

        // Simultaneous rd/we edges: write only.
        rc0 = n_rd_cmds;
        wc0 = n_wr_cmds;
        issue(1, 1, 21'h00040, 8'h77, 0);
        measure(low, wh);
        check("prio_wr_issued", 64'(n_wr_cmds), 64'(wc0 + 1));
        // rd edge during WR_REQ is lost.
        issue(0, 1, 21'h00048, 8'h33, 3);
        @(posedge clk);
        #2;
        addr = 21'h00100;
        rd = 1'b1;
        @(posedge clk);
        #2;
        rd = 1'b0;
        measure(low, wh);
        repeat (6) @(negedge clk);
        check("prio_ignore_no_rd", 64'(n_rd_cmds), 64'(rc0));

        // Reset in the middle of a read miss held by BUSY.
        issue(1, 0, 21'h00100, 8'h00, 20);
        @(posedge clk);
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst_mid_ready", 64'(ready), 64'd1);
        check("rst_mid_rd", 64'(DDRAM_RD), 64'd0);
        check("rst_mid_we", 64'(DDRAM_WE), 64'd0);
        check("rst_mid_dout", 64'(dout), 64'd0);
        exp_q.delete();
        m_valid = 1'b0;
        busy_set = 0;
        busy_tok++;
        repeat (2) @(posedge clk);
        #2;
        RESET_N = 1'b1;
        rc0 = n_rd_cmds;
        issue(1, 0, 21'h00000, 8'h00, 0);
        measure(low, wh);
        check("post_rst_miss_low", 64'(low), 64'd3);
        check("post_rst_rd_cmd", 64'(n_rd_cmds), 64'(rc0 + 1));

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            wait_idle();
            a = {lines[$urandom_range(0, 5)], 3'($urandom_range(0, 7))};
            op = $urandom_range(0, 9);
            if (op <= 5)      issue(1, 0, a, 8'h00, 0);
            else if (op <= 8) issue(0, 1, a, 8'($urandom), 0);
            else              issue(1, 1, a, 8'($urandom), 0);
        end
        wait_idle();
        rand_mode = 1'b0;
        repeat (4) @(negedge clk);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ddram_gs_bridge.md
# ddram_gs_bridge

Byte-wide memory port for the General Sound block onto the 64-bit DDR3 (Avalon-MM style) interface. It translates 8-bit read/write requests on a 21-bit byte address (2 MB window) into single-beat 64-bit DDR transactions. It also keeps a one-line (8-byte) read cache so sequential GS fetches avoid DDR latency. It sits between the TSConf core GS memory port (GS_ADDR/GS_DI/GS_DO/GS_RD/GS_WR/GS_WAIT) and the top-level DDRAM_* pins.

## Interface
No parameters.
- DDRAM_CLK  in  1  sole clock for all logic (84 MHz memory clock)
- RESET_N  in  1  asynchronous, active-low reset
- DDRAM_BUSY  in  1  DDR controller stall; a command is accepted on a clock where it is asserted and BUSY=0
- DDRAM_BURSTCNT  out  8  always 8'd1
- DDRAM_ADDR  out  29  64-bit word address = {4'b0011, 7'b0, addr[20:3]}, registered at request
- DDRAM_DOUT  in  64  read data
- DDRAM_DOUT_READY  in  1  read data valid strobe
- DDRAM_RD  out  1  read command
- DDRAM_DIN  out  64  write data = {8{din}}
- DDRAM_BE  out  8  byte enable = 8'b1 << addr[2:0]
- DDRAM_WE  out  1  write command
- addr  in  21  GS byte address
- din  in  8  GS write data
- dout  out  8  GS read data (registered)
- we  in  1  write request (rising edge)
- rd  in  1  read request (rising edge)
- ready  out  1  1 = idle/complete; 0 = transaction in progress (GS_WAIT = ~ready)

## Operation
- Request detection: rd and we are sampled each clock and compared with their previous sampled values. A 0→1 transition is a request. addr/din are captured in the same clock.
- Simultaneous rd and we rising edges: the write is performed and the read is dropped.
- Rising edges while not IDLE are ignored. The previous-value registers still update, so the request is lost. The master must wait for ready=1.
- Cache: one 64-bit line, an 18-bit tag (addr[20:3]) and a valid bit. Invalid after reset.
- States:
  - IDLE: waiting for a request.
    - Read edge with valid && tag==addr[20:3] (hit): dout <= line byte addr[2:0]. Stay in IDLE; ready stays 1.
    - Read miss: DDRAM_ADDR loaded, DDRAM_RD<=1, ready<=0, go to RD_REQ.
    - Write edge: DDRAM_ADDR/DIN/BE loaded, DDRAM_WE<=1, ready<=0, go to WR_REQ. If the cache tag matches, the cached byte is updated with din (write-through); the valid bit is unchanged.
  - RD_REQ: hold DDRAM_RD while BUSY=1. On a clock with BUSY=0: DDRAM_RD<=0, go to RD_WAIT.
  - RD_WAIT: on DDRAM_DOUT_READY=1: line<=DDRAM_DOUT, tag<=addr[20:3], valid<=1, dout<=DDRAM_DOUT byte addr[2:0], ready<=1, go to IDLE.
  - WR_REQ: hold DDRAM_WE while BUSY=1. On a clock with BUSY=0: DDRAM_WE<=0, ready<=1, go to IDLE.
- Byte selection: byte n of a 64-bit word is bits [8n+7:8n], with n = addr[2:0] (little-endian).
- Reset (asynchronous, any state): state=IDLE; ready=1; DDRAM_RD=0; DDRAM_WE=0; DDRAM_ADDR=0; DDRAM_DIN=0; DDRAM_BE=0; dout=0; valid=0; edge-history registers=0. Any transaction in flight is abandoned.

## Timing
- All outputs are registered except DDRAM_BURSTCNT, which is constant.
- Read hit: dout valid 1 clock after the sampled edge; ready never drops.
- Read miss: ready=0 and DDRAM_RD=1 from edge k+1.
  - RD drops the clock after BUSY=0 is sampled.
  - dout and ready=1 appear 1 clock after DOUT_READY is sampled.
  - Minimum latency with BUSY=0 and data one clock after the command: 3 clocks.
- Write: WE=1 for (1 + number of BUSY clocks) cycles; ready returns in the same clock WE drops. Minimum: 1 clock of ready=0.
- DDRAM_ADDR/DIN/BE stay stable while RD or WE is asserted.

## Test plan
- Reset: RESET_N=0 mid-read-miss → ready=1, DDRAM_RD=0, DDRAM_WE=0, dout=0. After release, a read of addr 0 misses and issues DDRAM_RD.
- Read miss: rd↑ at addr=21'h00009, BUSY=0, DOUT_READY one clock later with data 64'h8877665544332211 → DDRAM_ADDR=29'h06000001, BURSTCNT=1, dout=8'h22, ready low 3 clocks.
- Read hit: then rd↑ at addr=21'h0000F → no DDRAM_RD, dout=8'h88, ready stays 1.
- Write with stall: we↑ at addr=21'h1FFFFA, din=8'hA5, BUSY=1 for 3 clocks → WE high 4 clocks, DIN=64'hA5A5A5A5A5A5A5A5, BE=8'h04, ADDR=29'h0603FFFF, then ready=1.
- Write-through: write 8'h5A to addr 21'h0000A after the read-miss fill, then rd↑ at addr 21'h0000A → hit, dout=8'h5A, no DDRAM_RD.
- Priority and ignore: rd↑ and we↑ together → only DDRAM_WE, no DDRAM_RD. An rd↑ during WR_REQ produces no read afterwards.
